// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: combinational stall/flush priority network plus a
// memory-wait FSM with a sticky timeout flag and stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs_D,
  input  logic [4:0]       Rt_D,
  input  logic             use_rs_D,
  input  logic             use_rt_D,
  input  logic             RegWr_E,
  input  logic             MemtoReg_E,
  input  logic [4:0]       RegWrDst_E,
  input  logic             redirect_E,
  input  logic             mem_req_M,
  input  logic             mem_ready_M,
  output logic             PC_stall,
  output logic             IF_ID_stall,
  output logic             ID_Ex_stall,
  output logic             EX_MEM_stall,
  output logic             IF_ID_flush,
  output logic             ID_Ex_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // state    | meaning
  // RUN      | no outstanding memory wait
  // WAIT_MEM | MEM stage frozen on a pending request, wcnt counts wait cycles
  // TIMEOUT  | wait exceeded MAX_WAIT cycles; freeze still honoured until ready
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    TIMEOUT  = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t           state_q;
  logic [7:0]       wcnt_q;
  logic             timeout_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic freeze;
  logic load_use;

  assign freeze   = mem_req_M & ~mem_ready_M;
  assign load_use = RegWr_E & MemtoReg_E & (RegWrDst_E != 5'd0) &
                    ((use_rs_D & (RegWrDst_E == Rs_D)) |
                     (use_rt_D & (RegWrDst_E == Rt_D)));

  always_comb begin
    PC_stall     = 1'b0;
    IF_ID_stall  = 1'b0;
    ID_Ex_stall  = 1'b0;
    EX_MEM_stall = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_Ex_flush  = 1'b0;
    if (freeze) begin
      PC_stall     = 1'b1;
      IF_ID_stall  = 1'b1;
      ID_Ex_stall  = 1'b1;
      EX_MEM_stall = 1'b1;
    end else if (redirect_E) begin
      IF_ID_flush = 1'b1;
      ID_Ex_flush = 1'b1;
    end else if (load_use) begin
      // single bubble: hold PC and IF/ID, squash what enters EX
      PC_stall    = 1'b1;
      IF_ID_stall = 1'b1;
      ID_Ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      wcnt_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (freeze) begin
            state_q <= WAIT_MEM;
            wcnt_q  <= 8'd1;
          end
        end
        WAIT_MEM: begin
          if (mem_ready_M || !mem_req_M) begin
            state_q <= RUN;
            wcnt_q  <= 8'd0;
          end else if (wcnt_q == WAIT_LAST) begin
            state_q   <= TIMEOUT;
            timeout_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + 8'd1;
          end
        end
        TIMEOUT: begin
          if (!freeze) begin
            state_q <= RUN;
            wcnt_q  <= 8'd0;
          end
        end
        default: begin
          state_q <= RUN;
          wcnt_q  <= 8'd0;
        end
      endcase
    end
  end

  assign stall_cnt_d = PC_stall    ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign flush_cnt_d = ID_Ex_flush ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares against the DUT outputs.
module tb_hazard_ctrl;

  localparam int unsigned MAX_WAIT = 4;
  localparam int unsigned CNT_W    = 8;
  localparam logic [1:0] S_RUN = 2'd0, S_WAIT = 2'd1, S_TO = 2'd2;
  localparam logic [5:0] O_NONE = 6'h00, O_FRZ = 6'h3C, O_RED = 6'h03, O_LU = 6'h31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [4:0] Rs_D, Rt_D, RegWrDst_E;
  logic use_rs_D, use_rt_D, RegWr_E, MemtoReg_E, redirect_E, mem_req_M, mem_ready_M;
  logic PC_stall, IF_ID_stall, ID_Ex_stall, EX_MEM_stall, IF_ID_flush, ID_Ex_flush;
  logic mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [5:0] outs;
  logic [1:0] st_act;

  hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .use_rs_D(use_rs_D), .use_rt_D(use_rt_D),
    .RegWr_E(RegWr_E), .MemtoReg_E(MemtoReg_E), .RegWrDst_E(RegWrDst_E),
    .redirect_E(redirect_E), .mem_req_M(mem_req_M), .mem_ready_M(mem_ready_M),
    .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .ID_Ex_stall(ID_Ex_stall),
    .EX_MEM_stall(EX_MEM_stall), .IF_ID_flush(IF_ID_flush), .ID_Ex_flush(ID_Ex_flush),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign outs   = {PC_stall, IF_ID_stall, ID_Ex_stall, EX_MEM_stall, IF_ID_flush, ID_Ex_flush};
  assign st_act = dut.state_q;

  typedef struct {
    string      nm;
    logic [5:0] o;
    logic [7:0] sc;
    logic [7:0] fc;
    logic       to;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];
  logic [7:0] m_sc = 8'd0;
  logic [7:0] m_fc = 8'd0;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.nm, " outs"},        32'(outs),        32'(e.o));
      chk({e.nm, " stall_cnt"},   32'(stall_cnt),   32'(e.sc));
      chk({e.nm, " flush_cnt"},   32'(flush_cnt),   32'(e.fc));
      chk({e.nm, " mem_timeout"}, 32'(mem_timeout), 32'(e.to));
      chk({e.nm, " state"},       32'(st_act),      32'(e.st));
    end
  end

  // One cycle: apply inputs after the edge, queue what the monitor must see
  // before the next edge, then advance the counter model by this cycle's outputs.
  task automatic step(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic we, input logic mtr,
                      input logic [4:0] dst, input logic redir, input logic req,
                      input logic rdy, input logic [5:0] eo, input logic [1:0] est,
                      input logic eto);
    exp_t e;
    @(posedge clk);
    #1;
    Rs_D = rs; Rt_D = rt; use_rs_D = urs; use_rt_D = urt;
    RegWr_E = we; MemtoReg_E = mtr; RegWrDst_E = dst;
    redirect_E = redir; mem_req_M = req; mem_ready_M = rdy;
    e.nm = nm; e.o = eo; e.sc = m_sc; e.fc = m_fc; e.to = eto; e.st = est;
    sb.push_back(e);
    if (eo[5]) m_sc = m_sc + 8'd1;
    if (eo[0]) m_fc = m_fc + 8'd1;
  endtask

  task automatic idle(input string nm, input logic [1:0] est, input logic eto);
    step(nm, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, O_NONE, est, eto);
  endtask

  task automatic frz(input string nm, input logic redir, input logic [1:0] est, input logic eto);
    step(nm, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, redir, 1, 0, O_FRZ, est, eto);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] base_sc, base_fc;
    rst_n = 1'b0;
    Rs_D = 5'd5; Rt_D = 5'd0; use_rs_D = 1; use_rt_D = 0;
    RegWr_E = 1; MemtoReg_E = 1; RegWrDst_E = 5'd5;
    redirect_E = 0; mem_req_M = 0; mem_ready_M = 0;
    #3;
    chk("reset outs comb",   32'(outs), 32'(O_LU));
    chk("reset state",       32'(st_act), 32'(S_RUN));
    chk("reset stall_cnt",   32'(stall_cnt), 0);
    chk("reset flush_cnt",   32'(flush_cnt), 0);
    chk("reset mem_timeout", 32'(mem_timeout), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset holds stall_cnt", 32'(stall_cnt), 0);
    chk("reset holds flush_cnt", 32'(flush_cnt), 0);
    Rs_D = 0; use_rs_D = 0; RegWr_E = 0; MemtoReg_E = 0; RegWrDst_E = 0;
    @(negedge clk);
    rst_n = 1'b1;

    idle("idle0", S_RUN, 0);
    step("lu_rs",     5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 0, 0, 0, O_LU,   S_RUN, 0);
    idle("after_lu", S_RUN, 0);
    step("lu_rt",     5'd3, 5'd7, 1, 1, 1, 1, 5'd7, 0, 0, 0, O_LU,   S_RUN, 0);
    step("rt_unused", 5'd3, 5'd7, 1, 0, 1, 1, 5'd7, 0, 0, 0, O_NONE, S_RUN, 0);
    step("not_load",  5'd5, 5'd0, 1, 0, 1, 0, 5'd5, 0, 0, 0, O_NONE, S_RUN, 0);
    step("reg0",      5'd0, 5'd0, 1, 1, 1, 1, 5'd0, 0, 0, 0, O_NONE, S_RUN, 0);
    step("redir_lu",  5'd5, 5'd0, 1, 0, 1, 1, 5'd5, 1, 0, 0, O_RED,  S_RUN, 0);
    idle("after_redir", S_RUN, 0);

    frz("frz_redir1", 1, S_RUN, 0);
    frz("frz_redir2", 1, S_WAIT, 0);
    frz("frz_redir3", 1, S_WAIT, 0);
    step("ready", 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1, O_NONE, S_WAIT, 0);
    idle("back_run", S_RUN, 0);

    frz("to_frz1", 0, S_RUN, 0);
    frz("to_frz2", 0, S_WAIT, 0);
    frz("to_frz3", 0, S_WAIT, 0);
    frz("to_frz4", 0, S_WAIT, 0);
    frz("to_frz5", 0, S_TO, 1);
    frz("to_frz6", 0, S_TO, 1);
    step("to_ready", 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1, O_NONE, S_TO, 1);
    for (int i = 0; i < 10; i++) idle("to_sticky", S_RUN, 1);

    frz("wd_frz", 0, S_RUN, 1);
    idle("withdrawn", S_WAIT, 1);
    idle("wd_run", S_RUN, 1);

    frz("rst_frz1", 0, S_RUN, 1);
    frz("rst_frz2", 0, S_WAIT, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async state",       32'(st_act), 32'(S_RUN));
    chk("async stall_cnt",   32'(stall_cnt), 0);
    chk("async flush_cnt",   32'(flush_cnt), 0);
    chk("async mem_timeout", 32'(mem_timeout), 0);
    chk("async outs comb",   32'(outs), 32'(O_FRZ));
    #1 rst_n = 1'b1;
    // freeze is still applied at the next edge, so one stall is counted from zero
    m_sc = 8'd1;
    m_fc = 8'd0;
    frz("rst_frz3", 0, S_WAIT, 0);
    step("rst_ready", 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1, O_NONE, S_WAIT, 0);
    idle("rst_run", S_RUN, 0);

    base_sc = m_sc;
    base_fc = m_fc;
    for (int i = 0; i < 256; i++)
      step("wrap_lu", 5'd9, 5'd0, 1, 0, 1, 1, 5'd9, 0, 0, 0, O_LU, S_RUN, 0);
    idle("wrap_end", S_RUN, 0);
    @(negedge clk);
    #1;
    chk("stall_cnt wrapped", 32'(stall_cnt), 32'(base_sc));
    chk("flush_cnt wrapped", 32'(flush_cnt), 32'(base_fc));
    chk("scoreboard drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16: memory-wait cycles before timeout is flagged (legal range 2..255).
REQ-002 SHALL have parameter CNT_W, default 32: width of the performance counters.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port Rs_D, Rt_D  input  5 each  source register numbers of the instruction in ID.
REQ-006 SHALL have port use_rs_D, use_rt_D  input  1 each  the ID instruction reads Rs / Rt.
REQ-007 SHALL have port RegWr_E, MemtoReg_E  input  1 each  write-enable and load flag of the instruction in EX.
REQ-008 SHALL have port RegWrDst_E  input  5  destination register of the instruction in EX.
REQ-009 SHALL have port redirect_E  input  1  taken branch or jump resolved in EX.
REQ-010 SHALL have port mem_req_M, mem_ready_M  input  1 each  MEM-stage data-memory request and ready.
REQ-011 SHALL have port PC_stall, IF_ID_stall, ID_Ex_stall, EX_MEM_stall  output  1 each  hold the named register.
REQ-012 SHALL have port IF_ID_flush, ID_Ex_flush  output  1 each  clear the named register on the next edge.
REQ-013 SHALL have port mem_timeout  output  1  sticky memory-timeout flag.
REQ-014 SHALL have port stall_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-015 SHALL compute freeze = mem_req_M & ~mem_ready_M combinationally, with no added latency.
REQ-016 SHALL compute load_use = RegWr_E & MemtoReg_E & (RegWrDst_E != 0) & ((use_rs_D & RegWrDst_E == Rs_D) | (use_rt_D & RegWrDst_E == Rt_D)).
REQ-017 SHALL apply priority freeze > redirect_E > load_use; all stall and flush outputs are combinational in the same cycle.
REQ-018 SHALL, when freeze=1, assert all four stall outputs and deassert both flush outputs.
REQ-019 SHALL, when freeze=0 and redirect_E=1, assert IF_ID_flush and ID_Ex_flush and deassert all stall outputs, so the PC loads the redirect target.
REQ-020 SHALL, when freeze=0, redirect_E=0 and load_use=1, assert PC_stall, IF_ID_stall and ID_Ex_flush, with all other stall and flush outputs at 0 (one bubble).
REQ-021 SHALL otherwise drive all stall and flush outputs to 0.
REQ-022 SHALL use FSM states RUN, WAIT_MEM and TIMEOUT, held in a registered state and an 8-bit wait counter wcnt.
REQ-023 SHALL move RUN->WAIT_MEM when freeze=1, setting wcnt=1.
REQ-024 SHALL, in WAIT_MEM, go to RUN with wcnt=0 if mem_ready_M=1.
REQ-025 SHALL, in WAIT_MEM with freeze=1, go to TIMEOUT when wcnt==MAX_WAIT-1, and otherwise increment wcnt.
REQ-026 SHALL, in WAIT_MEM with mem_req_M=0, return to RUN because the request was withdrawn.
REQ-027 SHALL set mem_timeout=1 on entry to TIMEOUT.
REQ-028 SHALL keep mem_timeout at 1 until reset.
REQ-029 SHALL keep freeze semantics unchanged in TIMEOUT and go TIMEOUT->RUN when freeze=0.
REQ-030 SHALL increment stall_cnt every cycle in which PC_stall=1, wrapping modulo 2^CNT_W.
REQ-031 SHALL increment flush_cnt every cycle in which ID_Ex_flush=1, wrapping modulo 2^CNT_W.
REQ-032 SHALL never raise load_use for a destination of register 0, even if both Rs_D and Rt_D are 0.

Reset
REQ-033 SHALL, while rst_n=0 and regardless of clk, set state=RUN, wcnt=0, mem_timeout=0, stall_cnt=0 and flush_cnt=0.
REQ-034 SHALL keep combinational outputs a function of current inputs during reset.
REQ-035 SHALL, if reset is asserted mid-wait, restart in RUN on deassertion and re-enter WAIT_MEM if freeze is still 1.

Verification
REQ-036 SHALL cover load-use: RegWr_E=1, MemtoReg_E=1, RegWrDst_E=5, Rs_D=5, use_rs_D=1 -> PC_stall=1, IF_ID_stall=1, ID_Ex_flush=1 for one cycle, and stall_cnt goes 0->1.
REQ-037 SHALL cover register 0: the REQ-036 stimulus with RegWrDst_E=0 and Rs_D=0 -> all stall and flush outputs 0.
REQ-038 SHALL cover redirect priority: redirect_E=1 together with the load-use stimulus -> IF_ID_flush=1, ID_Ex_flush=1, PC_stall=0, and flush_cnt +1.
REQ-039 SHALL cover freeze priority: mem_req_M=1, mem_ready_M=0 together with redirect_E=1 for 3 cycles, then ready -> all four stalls 1 and flushes 0 for 3 cycles, state back to RUN, mem_timeout=0.
REQ-040 SHALL cover timeout: MAX_WAIT=4 with freeze held 6 cycles -> TIMEOUT entered after the 4th freeze cycle, mem_timeout=1, still 1 after ready and after 10 more cycles.
REQ-041 SHALL cover asynchronous reset: rst_n pulsed low mid-clock during WAIT_MEM with counters nonzero -> state=RUN, counters=0 and mem_timeout=0 immediately, without waiting for a clock edge.
